// File: rtl/ekf_slam_top.sv
// Stage controller/datapath for the EKF-SLAM accelerator: accepts one stage command,
// sweeps the 3+2N state rows, then multiplies, accumulates and saturates into S_data.
module ekf_slam_top #(
    parameter int RSA_DW        = 32,
    parameter int RSA_AW        = 17,
    parameter int ROW_LEN       = 10,
    parameter int DATA_DEC_BIT  = 19,
    parameter int ANGLE_DEC_BIT = 15
) (
    input  logic                clk,
    input  logic                sys_rst,
    input  logic [2:0]          stage_val,
    input  logic [ROW_LEN-1:0]  landmark_num,
    input  logic [ROW_LEN-1:0]  l_k,
    input  logic [RSA_DW-1:0]   vlr,
    input  logic [RSA_AW-1:0]   alpha,
    input  logic [RSA_DW-1:0]   rk,
    input  logic [RSA_AW-1:0]   phi,
    output logic [2:0]          stage_rdy,
    output logic [RSA_DW-1:0]   S_data
);

    localparam int PW = 2 * RSA_DW;
    localparam int RW = ROW_LEN + 2;

    localparam logic [2:0] CMD_PRD   = 3'd1;
    localparam logic [2:0] CMD_NEW   = 3'd2;
    localparam logic [2:0] CMD_UPD   = 3'd3;
    localparam logic [2:0] CMD_ASSOC = 3'd4;
    localparam logic [2:0] RDY_ERR   = 3'b111;

    localparam logic signed [PW:0] SAT_MAX = {{(PW-RSA_DW+2){1'b0}}, {(RSA_DW-1){1'b1}}};
    localparam logic signed [PW:0] SAT_MIN = {{(PW-RSA_DW+2){1'b1}}, {(RSA_DW-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_SWEEP, S_MUL, S_ACC, S_DONE} state_t;

    state_t state, state_nxt;

    logic [2:0]         cmd_q;
    logic [ROW_LEN-1:0] n_q, lk_q;
    logic [RSA_DW-1:0]  vlr_q, rk_q;
    logic [RSA_AW-1:0]  alpha_q, phi_q;
    logic [RW-1:0]      row_q;
    logic [RW-1:0]      row_last;

    logic signed [PW-1:0] prod_a, prod_b;
    logic signed [PW-1:0] vlr_x, alpha_x, rk_x, phi_x;
    logic signed [PW:0]   term_a, term_b, sum;
    logic [RSA_DW-1:0]    acc_q;

    logic cmd_valid, idx_bad_in, idx_bad_q;
    logic accept, sweep_last, in_sweep, in_mul, in_acc, in_done;

    assign cmd_valid  = (stage_val >= CMD_PRD) && (stage_val <= CMD_ASSOC);
    assign idx_bad_in = ((stage_val == CMD_NEW) || (stage_val == CMD_UPD)) &&
                        ((l_k == '0) || (l_k > landmark_num));
    assign idx_bad_q  = ((cmd_q == CMD_NEW) || (cmd_q == CMD_UPD)) &&
                        ((lk_q == '0) || (lk_q > n_q));
    assign row_last   = {1'b0, n_q, 1'b0} + RW'(2);
    assign sweep_last = (row_q == row_last);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all flops sample the same pre-edge values.
        if (!sys_rst) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first, so every path assigns and no latch is inferred.
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (cmd_valid) state_nxt = idx_bad_in ? S_DONE : S_SWEEP;
            S_SWEEP: if (sweep_last) state_nxt = S_MUL;
            S_MUL:   state_nxt = S_ACC;
            S_ACC:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output/control decode
    always_comb begin
        accept   = 1'b0;
        in_sweep = 1'b0;
        in_mul   = 1'b0;
        in_acc   = 1'b0;
        in_done  = 1'b0;
        unique case (state)
            S_IDLE:  accept   = cmd_valid;
            S_SWEEP: in_sweep = 1'b1;
            S_MUL:   in_mul   = 1'b1;
            S_ACC:   in_acc   = 1'b1;
            S_DONE:  in_done  = 1'b1;
            default: ;
        endcase
    end

    assign vlr_x   = {{(PW-RSA_DW){vlr_q[RSA_DW-1]}}, vlr_q};
    assign rk_x    = {{(PW-RSA_DW){rk_q[RSA_DW-1]}}, rk_q};
    assign alpha_x = {{(PW-RSA_AW){alpha_q[RSA_AW-1]}}, alpha_q};
    assign phi_x   = {{(PW-RSA_AW){phi_q[RSA_AW-1]}}, phi_q};

    // Rescale the products back to Q12.19; phi*phi is Q4.30 so it needs 2*15-19 bits.
    always_comb begin
        term_a = {prod_a[PW-1], prod_a};
        term_b = {prod_b[PW-1], prod_b};
        if ((cmd_q == CMD_PRD) || (cmd_q == CMD_NEW)) term_a = term_a >>> ANGLE_DEC_BIT;
        else                                          term_a = term_a >>> DATA_DEC_BIT;
        term_b = term_b >>> (2 * ANGLE_DEC_BIT - DATA_DEC_BIT);
        sum    = (cmd_q == CMD_ASSOC) ? term_a + term_b : term_a;
    end

    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            cmd_q     <= '0;
            n_q       <= '0;
            lk_q      <= '0;
            vlr_q     <= '0;
            alpha_q   <= '0;
            rk_q      <= '0;
            phi_q     <= '0;
            row_q     <= '0;
            prod_a    <= '0;
            prod_b    <= '0;
            acc_q     <= '0;
            stage_rdy <= '0;
            S_data    <= '0;
        end else begin
            if (accept) begin
                cmd_q     <= stage_val;
                n_q       <= landmark_num;
                lk_q      <= l_k;
                vlr_q     <= vlr;
                alpha_q   <= alpha;
                rk_q      <= rk;
                phi_q     <= phi;
                row_q     <= '0;
                stage_rdy <= '0;
            end
            if (in_sweep) row_q <= row_q + RW'(1);
            if (in_mul) begin
                unique case (cmd_q)
                    CMD_PRD: prod_a <= vlr_x * alpha_x;
                    CMD_NEW: prod_a <= rk_x * phi_x;
                    default: prod_a <= rk_x * rk_x;
                endcase
                prod_b <= phi_x * phi_x;
            end
            if (in_acc) begin
                if (sum > SAT_MAX)      acc_q <= SAT_MAX[RSA_DW-1:0];
                else if (sum < SAT_MIN) acc_q <= SAT_MIN[RSA_DW-1:0];
                else                    acc_q <= sum[RSA_DW-1:0];
            end
            if (in_done) begin
                if (idx_bad_q) begin
                    stage_rdy <= RDY_ERR;
                end else begin
                    stage_rdy <= cmd_q;
                    S_data    <= acc_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_ekf_slam_top.sv
// Self-checking bench for ekf_slam_top: scoreboard of expected results, latency and
// result checks for every stage, index errors, ignored commands, busy and abort cases.
module tb_ekf_slam_top;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [2:0]  stage_val;
    logic [9:0]  landmark_num, l_k;
    logic [31:0] vlr, rk;
    logic [16:0] alpha, phi;
    logic [2:0]  stage_rdy;
    logic [31:0] S_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  rdy;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];

    ekf_slam_top dut (
        .clk(clk), .sys_rst(sys_rst), .stage_val(stage_val),
        .landmark_num(landmark_num), .l_k(l_k), .vlr(vlr), .alpha(alpha),
        .rk(rk), .phi(phi), .stage_rdy(stage_rdy), .S_data(S_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference arithmetic in 64-bit integers, saturated to 32 bits.
    function automatic logic [31:0] model(input logic [2:0] code, input logic [31:0] v,
                                          input logic [16:0] a, input logic [31:0] r,
                                          input logic [16:0] p);
        longint sv, sa, sr, sp, res;
        sv = longint'($signed(v));
        sa = longint'($signed(a));
        sr = longint'($signed(r));
        sp = longint'($signed(p));
        case (code)
            3'd1:    res = (sv * sa) >>> 15;
            3'd2:    res = (sr * sp) >>> 15;
            3'd3:    res = (sr * sr) >>> 19;
            default: res = ((sr * sr) >>> 19) + ((sp * sp) >>> 11);
        endcase
        if (res > 64'sd2147483647)       res = 64'sd2147483647;
        else if (res < -64'sd2147483648) res = -64'sd2147483648;
        return res[31:0];
    endfunction

    // Drives one command from a negedge, then waits for completion; optionally pokes a
    // second command and scrambled operands while the first one is running.
    task automatic run_cmd(input string tag, input logic [2:0] code, input logic [9:0] n,
                           input logic [9:0] lk, input logic [31:0] v, input logic [16:0] a,
                           input logic [31:0] r, input logic [16:0] p,
                           input logic [2:0] erdy, input logic [31:0] edata, input int elat,
                           input int hold, input int poke);
        exp_t e;
        int   cnt;
        bit   got;
        stage_val    = code;
        landmark_num = n;
        l_k          = lk;
        vlr          = v;
        alpha        = a;
        rk           = r;
        phi          = p;
        sb.push_back('{erdy, edata, elat});
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 3000) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (cnt == 1) check({tag, "_clear"}, {29'd0, stage_rdy}, 32'd0);
            if (cnt == hold) stage_val = 3'd0;
            if (cnt == poke) begin
                stage_val = 3'd4;
                vlr = '0; alpha = '0; rk = 32'h1234_5678; phi = 17'h1_0000;
            end
            if (poke > 0 && cnt == poke + 2) stage_val = 3'd0;
            if (stage_rdy != 3'd0) got = 1'b1;
        end
        stage_val = 3'd0;
        e = sb.pop_front();
        if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
        check({tag, "_rdy"}, {29'd0, stage_rdy}, {29'd0, e.rdy});
        check({tag, "_data"}, S_data, e.data);
        check({tag, "_lat"}, 32'(cnt - 1), 32'(e.lat));
    endtask

    initial begin
        logic [2:0]  rc;
        logic [9:0]  rn, rl;
        logic [31:0] rv, rr;
        logic [16:0] ra, rp;

        sys_rst = 1'b0;
        stage_val = 3'd3;
        landmark_num = 10'd4; l_k = 10'd2;
        vlr = '0; alpha = '0; rk = 32'h0020_0000; phi = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rdy", {29'd0, stage_rdy}, 32'd0);
        check("reset_data", S_data, 32'd0);
        stage_val = 3'd0;
        sys_rst = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_after_reset_rdy", {29'd0, stage_rdy}, 32'd0);

        run_cmd("prd", 3'd1, 10'd4, 10'd0, 32'h0010_0000, 17'h4000, '0, '0,
                3'd1, 32'h0008_0000, 14, 2, 0);
        run_cmd("upd", 3'd3, 10'd4, 10'd2, '0, '0, 32'h0020_0000, '0,
                3'd3, 32'h0080_0000, 14, 1, 0);
        run_cmd("upd_sat", 3'd3, 10'd4, 10'd2, '0, '0, 32'h7FFF_FFFF, '0,
                3'd3, 32'h7FFF_FFFF, 14, 1, 0);
        run_cmd("new", 3'd2, 10'd4, 10'd4, '0, '0, 32'h0020_0000, 17'h4000,
                3'd2, 32'h0010_0000, 14, 1, 0);
        run_cmd("assoc", 3'd4, 10'd4, 10'd0, '0, '0, 32'h0020_0000, 17'h4000,
                3'd4, 32'h0082_0000, 14, 1, 0);
        run_cmd("err_upd", 3'd3, 10'd4, 10'd5, '0, '0, 32'h0040_0000, '0,
                3'b111, 32'h0082_0000, 1, 1, 0);

        stage_val = 3'd6;
        repeat (6) @(negedge clk);
        check("ignore6_rdy", {29'd0, stage_rdy}, 32'h7);
        check("ignore6_data", S_data, 32'h0082_0000);
        stage_val = 3'd0;

        run_cmd("err_new", 3'd2, 10'd3, 10'd0, '0, '0, 32'h0040_0000, 17'h100,
                3'b111, 32'h0082_0000, 1, 1, 0);
        run_cmd("prd_neg", 3'd1, 10'd2, 10'd0, 32'hFFF0_0000, 17'h4000, '0, '0,
                3'd1, 32'hFFF8_0000, 10, 1, 0);
        run_cmd("new_sat_neg", 3'd2, 10'd1, 10'd1, '0, '0, 32'h7FFF_FFFF, 17'h1_0000,
                3'd2, 32'h8000_0000, 8, 1, 0);

        for (int i = 0; i < 4; i++) begin
            rc = 3'($urandom_range(1, 4));
            rn = 10'($urandom_range(1, 6));
            rl = 10'($urandom_range(1, 32'(rn)));
            rv = $urandom;
            ra = 17'($urandom);
            rr = $urandom;
            rp = 17'($urandom);
            run_cmd($sformatf("rnd%0d", i), rc, rn, rl, rv, ra, rr, rp,
                    rc, model(rc, rv, ra, rr, rp), 2 * 32'(rn) + 6, 1, 0);
        end

        run_cmd("busy", 3'd1, 10'd4, 10'd0, 32'h0010_0000, 17'h4000, '0, '0,
                3'd1, 32'h0008_0000, 14, 1, 3);

        stage_val = 3'd3; landmark_num = 10'd4; l_k = 10'd2; rk = 32'h0020_0000;
        @(posedge clk);
        @(negedge clk);
        stage_val = 3'd0;
        repeat (4) @(negedge clk);
        sys_rst = 1'b0;
        @(negedge clk);
        check("abort_rdy", {29'd0, stage_rdy}, 32'd0);
        check("abort_data", S_data, 32'd0);
        sys_rst = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_idle_rdy", {29'd0, stage_rdy}, 32'd0);
        check("abort_idle_data", S_data, 32'd0);

        run_cmd("prd_n0", 3'd1, 10'd0, 10'd0, 32'h0010_0000, 17'h4000, '0, '0,
                3'd1, 32'h0008_0000, 6, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
